// File: rtl/axil_pkg.sv
// Shared types, constants and address helpers for the AXI4-Lite slave memory.
package axil_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  // Byte address bits [1:0] never take part in decoding.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] a;
    a = {1'b0, addr[31:2], 2'b00};
    return (a >= {1'b0, base}) && (a < ({1'b0, base} + span));
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] a;
    a = {addr[31:2], 2'b00} - base;
    return {2'b00, a[31:2]};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] nxt_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? nxt_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_mem_array.sv
// Word-addressed storage: one byte-enable synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module axil_mem_array #(
  parameter int unsigned DEPTH = 32'd1024,
  parameter int unsigned IDX_W = 32'd10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && wstrb[i]) begin
        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave memory with independent write and read FSMs, optional fixed
// access latency, write-first read collision and a sticky address-error flag.
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32'd1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 32'd1);
  localparam logic        WAIT_NONE = (WAIT_CYCLES == 32'd0);

  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [31:0] waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d, wcnt_q, wcnt_d;
  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, addr_err_q, addr_err_d;
  logic [31:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic [3:0]  rcnt_q, rcnt_d;

  logic        aw_hs_s, w_hs_s, ar_hs_s, wr_commit_s, wr_in_range_s, rd_in_range_s, mem_we_s;
  logic [31:0] wr_addr_s, wr_data_s, rd_addr_s, wr_off_s, rd_off_s, mem_rdata_s, rd_word_s;
  logic [3:0]  wr_strb_s;
  logic        unused_s;

  assign aw_hs_s = awvalid && awready_q;
  assign w_hs_s  = wvalid && wready_q;
  assign ar_hs_s = arvalid && arready_q;

  // Commit payload comes straight from the bus when the last half arrives this cycle.
  assign wr_addr_s = ((w_state_q == W_IDLE) && aw_hs_s) ? awaddr : waddr_q;
  assign wr_data_s = ((w_state_q == W_IDLE) && w_hs_s)  ? wdata  : wdata_q;
  assign wr_strb_s = ((w_state_q == W_IDLE) && w_hs_s)  ? wstrb  : wstrb_q;
  assign rd_addr_s = (r_state_q == R_IDLE) ? araddr : raddr_q;

  assign wr_in_range_s = addr_in_range(wr_addr_s, BASE_ADDR, SPAN);
  assign rd_in_range_s = addr_in_range(rd_addr_s, BASE_ADDR, SPAN);
  assign wr_off_s      = word_offset(wr_addr_s, BASE_ADDR);
  assign rd_off_s      = word_offset(rd_addr_s, BASE_ADDR);
  assign mem_we_s      = wr_commit_s && wr_in_range_s && !reset;
  assign unused_s      = ^{awprot, arprot, wr_off_s[31:IDX_W], rd_off_s[31:IDX_W]};

  axil_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_off_s[IDX_W-1:0]),
    .wdata (wr_data_s),
    .wstrb (wr_strb_s),
    .raddr (rd_off_s[IDX_W-1:0]),
    .rdata (mem_rdata_s)
  );

  // Write FSM next state: collect AW and W, optional wait, commit, respond.
  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wcnt_d      = wcnt_q;
    wr_commit_s = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_d = 1'b1;
          awready_d = 1'b0;
          waddr_d   = awaddr;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          w_held_d = 1'b1;
          wready_d = 1'b0;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end else begin
          w_held_d = w_held_q;
        end
        if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          wcnt_d    = 4'd0;
          if (WAIT_NONE) begin
            wr_commit_s = 1'b1;
            bvalid_d    = 1'b1;
            w_state_d   = W_RESP;
          end else begin
            w_state_d = W_WAIT;
          end
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          wr_commit_s = 1'b1;
          bvalid_d    = 1'b1;
          wcnt_d      = 4'd0;
          w_state_d   = W_RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        awready_d = 1'b1;
        wready_d  = 1'b1;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read sample value, forwarding a same-cycle commit to the same word.
  always_comb begin
    if (!rd_in_range_s) begin
      rd_word_s = OOR_RDATA;
    end else if (mem_we_s && (wr_off_s[IDX_W-1:0] == rd_off_s[IDX_W-1:0])) begin
      rd_word_s = merge_bytes(mem_rdata_s, wr_data_s, wr_strb_s);
    end else begin
      rd_word_s = mem_rdata_s;
    end
  end

  // Read FSM next state: accept AR, optional wait, sample, hold data until rready.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          raddr_d   = araddr;
          arready_d = 1'b0;
          rcnt_d    = 4'd0;
          if (WAIT_NONE) begin
            rdata_d   = rd_word_s;
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rcnt_q == WAIT_LAST) begin
          rdata_d   = rd_word_s;
          rvalid_d  = 1'b1;
          rcnt_d    = 4'd0;
          r_state_d = R_DATA;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Sticky flag for any accepted out-of-range address.
  always_comb begin
    addr_err_d = addr_err_q;
    if ((aw_hs_s && !addr_in_range(awaddr, BASE_ADDR, SPAN)) ||
        (ar_hs_s && !addr_in_range(araddr, BASE_ADDR, SPAN))) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      waddr_q    <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      wcnt_q     <= 4'd0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      raddr_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      rcnt_q     <= 4'd0;
      addr_err_q <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wcnt_q     <= wcnt_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rcnt_q     <= rcnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_axil_slave_mem.sv
// Randomized bench for axil_slave_mem: two instances (zero-latency at base 0,
// three-cycle latency at base 0x1000) checked against an associative-array model.
module tb_axil_slave_mem;

  logic        clk;
  logic        reset;
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] awaddr  [2];
  logic [2:0]  awprot  [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic [2:0]  arprot  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic        addr_err[2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [int];
  bit err_mdl [2];

  axil_slave_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .awvalid(awvalid[0]), .awready(awready[0]), .awaddr(awaddr[0]), .awprot(awprot[0]),
    .wvalid(wvalid[0]), .wready(wready[0]), .wdata(wdata[0]), .wstrb(wstrb[0]),
    .bvalid(bvalid[0]), .bready(bready[0]),
    .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr[0]), .arprot(arprot[0]),
    .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]), .addr_err(addr_err[0]));

  axil_slave_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset),
    .awvalid(awvalid[1]), .awready(awready[1]), .awaddr(awaddr[1]), .awprot(awprot[1]),
    .wvalid(wvalid[1]), .wready(wready[1]), .wdata(wdata[1]), .wstrb(wstrb[1]),
    .bvalid(bvalid[1]), .bready(bready[1]),
    .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr[1]), .arprot(arprot[1]),
    .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]), .addr_err(addr_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction
  function automatic logic [31:0] span_of(input int d);
    return (d == 0) ? 32'd4096 : 32'd64;
  endfunction
  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    longint unsigned aa;
    aa = 64'(a);
    return (aa >= 64'(base_of(d))) && (aa < 64'(base_of(d)) + 64'(span_of(d)));
  endfunction
  function automatic int key_of(input int d, input logic [31:0] a);
    return d * 4096 + int'((a - base_of(d)) / 32'd4);
  endfunction

  function automatic logic [31:0] expect_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [3:0] strb);
    int k;
    if (in_rng(d, a)) begin
      k = key_of(d, a);
      mdl[k] = expect_merge(mdl.exists(k) ? mdl[k] : 32'h0000_0000, data, strb);
    end else begin
      err_mdl[d] = 1'b1;
    end
  endtask

  function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
    if (!in_rng(d, a)) return 32'h0000_0000;
    return mdl[key_of(d, a)];
  endfunction

  task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] data,
                           input logic [3:0] strb, output int lat);
    bit aw_done, w_done, aw_go, w_go;
    int cyc;
    awaddr[d] = a; wdata[d] = data; wstrb[d] = strb; awprot[d] = 3'($urandom);
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      aw_go = awvalid[d] && awready[d];
      w_go  = wvalid[d] && wready[d];
      @(posedge clk); #1; cyc++;
      if (aw_go) begin awvalid[d] = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid[d]  = 1'b0; w_done  = 1'b1; end
    end
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    check_eq("write_accept", 32'(aw_done && w_done), 32'd1);
    lat = 0;
    while (!bvalid[d] && lat < 64) begin @(posedge clk); #1; lat++; end
    check_eq("bvalid_seen", 32'(bvalid[d]), 32'd1);
    bready[d] = 1'b1;
    @(posedge clk); #1;
    bready[d] = 1'b0;
    check_eq("bvalid_drop", 32'(bvalid[d]), 32'd0);
    check_eq("awready_back", 32'(awready[d] && wready[d]), 32'd1);
  endtask

  task automatic axi_read(input int d, input logic [31:0] a, input int stall,
                          output logic [31:0] data, output int lat);
    bit done, go;
    int cyc;
    araddr[d] = a; arprot[d] = 3'($urandom); arvalid[d] = 1'b1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 64) begin
      go = arready[d];
      @(posedge clk); #1; cyc++;
      if (go) done = 1'b1;
    end
    arvalid[d] = 1'b0;
    check_eq("read_accept", 32'(done), 32'd1);
    lat = 0;
    while (!rvalid[d] && lat < 64) begin @(posedge clk); #1; lat++; end
    check_eq("rvalid_seen", 32'(rvalid[d]), 32'd1);
    data = rdata[d];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("rdata_stable", rdata[d], data);
      check_eq("rvalid_hold", 32'(rvalid[d]), 32'd1);
      check_eq("arready_low", 32'(arready[d]), 32'd0);
    end
    rready[d] = 1'b1;
    @(posedge clk); #1;
    rready[d] = 1'b0;
    check_eq("rvalid_drop", 32'(rvalid[d]), 32'd0);
    check_eq("arready_back", 32'(arready[d]), 32'd1);
  endtask

  function automatic logic [31:0] pick_addr(input int d);
    int pool [8];
    int sel;
    pool = '{0, 1, 2, 3, 4, 8, 12, 0};
    pool[7] = int'(span_of(d) / 32'd4) - 1;
    if ($urandom_range(0, 9) == 0) begin
      sel = int'($urandom_range(0, 2));
      if (d == 0) return (sel == 0) ? 32'hFFFF_FFFC : 32'h0000_1000 + 32'($urandom_range(0, 15)) * 32'd4;
      if (sel == 0) return 32'h0000_0FFC;
      if (sel == 1) return 32'h0000_0000;
      return 32'h0000_1040 + 32'($urandom_range(0, 15)) * 32'd4;
    end
    return base_of(d) + 32'(pool[$urandom_range(0, 7)]) * 32'd4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] a, data, got, exp, old_w;
    logic [3:0]  strb;
    int lat, lat2, d, kind;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      awvalid[i] = 1'b0; awaddr[i] = 32'h0; awprot[i] = 3'd0;
      wvalid[i] = 1'b0; wdata[i] = 32'h0; wstrb[i] = 4'h0; bready[i] = 1'b0;
      arvalid[i] = 1'b0; araddr[i] = 32'h0; arprot[i] = 3'd0; rready[i] = 1'b0;
      err_mdl[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ready", 32'({awready[i], wready[i], arready[i]}), 32'd7);
      check_eq("rst_valid", 32'({bvalid[i], rvalid[i], addr_err[i]}), 32'd0);
      check_eq("rst_rdata", rdata[i], 32'h0000_0000);
    end

    // Give every word the random traffic can hit a known value.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 13; w++) begin
        a = base_of(i) + 32'(w) * 32'd4;
        data = $urandom;
        axi_write(i, a, data, 4'hF, lat);
        mdl_write(i, a, data, 4'hF);
      end
      a = base_of(i) + span_of(i) - 32'd4;
      data = $urandom;
      axi_write(i, a, data, 4'hF, lat);
      mdl_write(i, a, data, 4'hF);
      check_eq("init_b_lat", 32'(lat), 32'(wait_of(i)));
    end

    // Simultaneous AW+W, then read back with single-cycle latency.
    axi_write(0, 32'h10, 32'hA5A5_1234, 4'hF, lat);
    mdl_write(0, 32'h10, 32'hA5A5_1234, 4'hF);
    check_eq("aw_w_same_lat", 32'(lat), 32'd0);
    axi_read(0, 32'h10, 0, got, lat);
    check_eq("rd_0x10", got, 32'hA5A5_1234);
    check_eq("rd_lat0", 32'(lat), 32'd0);

    // W first, AW three cycles later.
    wdata[0] = 32'h1111_2222; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    check_eq("w_first_wready_pre", 32'(wready[0]), 32'd1);
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    check_eq("w_first_wready_low", 32'(wready[0]), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("w_first_no_b", 32'(bvalid[0]), 32'd0);
    end
    awaddr[0] = 32'h20; awvalid[0] = 1'b1;
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    check_eq("w_first_bvalid", 32'(bvalid[0]), 32'd1);
    check_eq("w_first_awready", 32'(awready[0]), 32'd0);
    bready[0] = 1'b1;
    @(posedge clk); #1;
    bready[0] = 1'b0;
    mdl_write(0, 32'h20, 32'h1111_2222, 4'hF);
    axi_read(0, 32'h20, 0, got, lat);
    check_eq("rd_0x20", got, 32'h1111_2222);

    // Partial strobe.
    axi_write(0, 32'h30, 32'hFFFF_FFFF, 4'hF, lat);
    mdl_write(0, 32'h30, 32'hFFFF_FFFF, 4'hF);
    axi_write(0, 32'h30, 32'h0000_0000, 4'b0101, lat);
    mdl_write(0, 32'h30, 32'h0000_0000, 4'b0101);
    axi_read(0, 32'h30, 0, got, lat);
    check_eq("rd_strb", got, 32'hFF00_FF00);

    // Out-of-range write one past the end: responded, dropped, flagged.
    check_eq("addr_err_pre", 32'(addr_err[0]), 32'd0);
    axi_write(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, lat);
    mdl_write(0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    check_eq("oor_b_lat", 32'(lat), 32'd0);
    check_eq("oor_addr_err", 32'(addr_err[0]), 32'd1);
    axi_read(0, 32'h0000_1000, 0, got, lat);
    check_eq("oor_rdata", got, 32'h0000_0000);
    axi_read(0, 32'h0000_0000, 0, got, lat);
    check_eq("oor_word0_kept", got, mdl_read(0, 32'h0));

    // Long-latency read with rready stalled.
    axi_read(1, 32'h0000_100C, 5, got, lat);
    check_eq("stall_rdata", got, mdl_read(1, 32'h0000_100C));
    check_eq("stall_lat", 32'(lat), 32'd3);

    // Random traffic, including simultaneous write+read of one word.
    for (int it = 0; it < 80; it++) begin
      d = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      a = pick_addr(d);
      data = $urandom;
      strb = 4'($urandom);
      if (kind == 0) begin
        axi_write(d, a, data, strb, lat);
        mdl_write(d, a, data, strb);
        check_eq("rnd_b_lat", 32'(lat), 32'(wait_of(d)));
      end else if (kind == 1) begin
        axi_read(d, a, int'($urandom_range(0, 2)), got, lat);
        if (!in_rng(d, a)) err_mdl[d] = 1'b1;
        check_eq("rnd_rdata", got, mdl_read(d, a));
        check_eq("rnd_r_lat", 32'(lat), 32'(wait_of(d)));
      end else begin
        mdl_write(d, a, data, strb);
        exp = mdl_read(d, a);
        fork
          axi_write(d, a, data, strb, lat);
          axi_read(d, a, 0, got, lat2);
        join
        check_eq("wr_first_rdata", got, exp);
        check_eq("wr_first_lat", 32'(lat2), 32'(wait_of(d)));
      end
      check_eq("rnd_addr_err", 32'(addr_err[d]), 32'(err_mdl[d]));
    end

    // Reset while the write sits in its wait phase.
    old_w = mdl_read(1, 32'h0000_1008);
    awaddr[1] = 32'h0000_1008; wdata[1] = ~old_w; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    @(posedge clk); #1;
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    err_mdl[0] = 1'b0; err_mdl[1] = 1'b0;
    check_eq("rst_mid_bvalid", 32'(bvalid[1]), 32'd0);
    check_eq("rst_mid_ready", 32'({awready[1], wready[1]}), 32'd3);
    check_eq("rst_mid_addr_err", 32'(addr_err[1]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_mid_no_b", 32'(bvalid[1]), 32'd0);
    axi_read(1, 32'h0000_1008, 0, got, lat);
    check_eq("rst_mid_word", got, old_w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
